// File: rtl/sd_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sd_cmd_responder
// Purpose : SD card-side CMD-line responder (CRC7 check, reduced card FSM,
//           R1/R3/R6/R7 responses) standing in for a physical card.
// Revision: 1.0
// ============================================================================
module sd_cmd_responder #(
    parameter logic [15:0] RCA        = 16'h1234,
    parameter logic [31:0] OCR        = 32'h40FF8000,
    parameter int          BUSY_COUNT = 2,
    parameter int          NCR        = 2
) (
    input  logic       sd_clk,
    input  logic       rst_n,
    input  logic       cmd_in,
    output logic       cmd_out,
    output logic       cmd_oe,
    output logic       cmd_done,
    output logic [5:0] cmd_index,
    output logic       crc_error,
    output logic       illegal_cmd,
    output logic [2:0] card_state
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_READY    = 3'd1;
    localparam logic [2:0] c_STBY     = 3'd3;
    localparam logic [2:0] c_TRAN     = 3'd4;
    localparam logic [6:0] c_NCR_LAST = 7'(NCR - 1);
    localparam logic [7:0] c_BUSY_MAX = 8'(BUSY_COUNT);

    typedef enum logic [2:0] {S_RX_WAIT, S_RX_SHIFT, S_CHECK, S_GAP, S_TX} state_t;

    state_t      r_state, w_state;
    logic [47:0] r_rx, w_rx, r_tx, w_tx;
    logic [6:0]  r_cnt, w_cnt;
    logic [7:0]  r_busy, w_busy;
    logic        r_app, w_app;
    logic        r_cmd_out, w_cmd_out, r_cmd_oe, w_cmd_oe;
    logic        r_done, w_done, r_crc_err, w_crc_err, r_illegal, w_illegal;
    logic [5:0]  r_index, w_index;
    logic [2:0]  r_card, w_card;

    logic [5:0]  w_idx;
    logic        w_frame_ok, w_busy_done, w_accept, w_resp_en, w_no_crc;
    logic [31:0] w_status;
    logic [39:0] w_hdr;

    // Serial CRC7 (x^7 + x^3 + 1, seed 0) over 40 header bits, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign w_idx       = r_rx[45:40];
    assign w_frame_ok  = !r_rx[47] && r_rx[46] && r_rx[0] && (crc7(r_rx[47:8]) == r_rx[7:1]);
    assign w_busy_done = (r_busy == c_BUSY_MAX);
    // R1 status: prior card state, READY_FOR_DATA, APP_CMD only for CMD55.
    assign w_status    = {19'h0, 1'b0, r_card, 1'b1, 2'b00, (w_idx == 6'd55), 5'h00};

    always_comb begin
        w_state   = r_state;
        w_rx      = r_rx;
        w_tx      = r_tx;
        w_cnt     = r_cnt;
        w_busy    = r_busy;
        w_app     = r_app;
        w_cmd_out = r_cmd_out;
        w_cmd_oe  = r_cmd_oe;
        w_done    = 1'b0;
        w_crc_err = 1'b0;
        w_illegal = 1'b0;
        w_index   = r_index;
        w_card    = r_card;
        w_accept  = 1'b0;
        w_resp_en = 1'b0;
        w_no_crc  = 1'b0;
        w_hdr     = '0;
        case (r_state)
            S_RX_WAIT: begin
                if (!cmd_in) begin
                    w_rx    = {r_rx[46:0], cmd_in};
                    w_cnt   = 7'd0;
                    w_state = S_RX_SHIFT;
                end
            end
            S_RX_SHIFT: begin
                w_rx  = {r_rx[46:0], cmd_in};
                w_cnt = r_cnt + 7'd1;
                if (r_cnt == 7'd46) w_state = S_CHECK;
            end
            S_CHECK: begin
                w_state = S_RX_WAIT;
                if (!w_frame_ok) begin
                    w_crc_err = 1'b1;
                end else begin
                    case (w_idx)
                        6'd0: begin
                            w_accept = 1'b1;
                            w_card   = c_IDLE;
                            w_busy   = 8'd0;
                        end
                        6'd8: begin
                            w_accept  = 1'b1;
                            w_resp_en = 1'b1;
                            w_hdr     = {2'b00, 6'd8, 20'h0, r_rx[19:8]};
                        end
                        6'd55: begin
                            w_accept  = 1'b1;
                            w_resp_en = 1'b1;
                            w_hdr     = {2'b00, w_idx, w_status};
                        end
                        6'd41: begin
                            if (r_app) begin
                                w_accept  = 1'b1;
                                w_resp_en = 1'b1;
                                w_no_crc  = 1'b1;
                                w_hdr     = {2'b00, 6'h3F, OCR | {w_busy_done, 31'h0}};
                                if (w_busy_done) w_card = c_READY;
                                else             w_busy = r_busy + 8'd1;
                            end
                        end
                        6'd3: begin
                            if (r_card == c_READY) begin
                                w_accept  = 1'b1;
                                w_resp_en = 1'b1;
                                w_hdr     = {2'b00, 6'd3, RCA, 16'h0500};
                                w_card    = c_STBY;
                            end
                        end
                        6'd7: begin
                            if (r_rx[39:24] != RCA) begin
                                w_accept = 1'b1;
                                w_card   = c_STBY;
                            end else if (r_card == c_STBY) begin
                                w_accept  = 1'b1;
                                w_resp_en = 1'b1;
                                w_hdr     = {2'b00, w_idx, w_status};
                                w_card    = c_TRAN;
                            end
                        end
                        6'd16: begin
                            if (r_card == c_TRAN) begin
                                w_accept  = 1'b1;
                                w_resp_en = 1'b1;
                                w_hdr     = {2'b00, w_idx, w_status};
                            end
                        end
                        default: ;
                    endcase
                    w_illegal = !w_accept;
                    if (w_accept) begin
                        w_done  = 1'b1;
                        w_index = w_idx;
                        w_app   = (w_idx == 6'd55);
                    end else begin
                        w_app = 1'b0;
                    end
                end
                if (w_resp_en) begin
                    w_state = S_GAP;
                    w_cnt   = 7'd0;
                    w_tx    = {w_hdr, (w_no_crc ? 7'h7F : crc7(w_hdr)), 1'b1};
                end
            end
            S_GAP: begin
                // The first response bit goes out on the same edge that raises cmd_oe.
                if (r_cnt == c_NCR_LAST) begin
                    w_state   = S_TX;
                    w_cnt     = 7'd0;
                    w_cmd_oe  = 1'b1;
                    w_cmd_out = r_tx[47];
                    w_tx      = {r_tx[46:0], 1'b1};
                end else begin
                    w_cnt = r_cnt + 7'd1;
                end
            end
            S_TX: begin
                if (r_cnt == 7'd47) begin
                    w_state   = S_RX_WAIT;
                    w_cmd_oe  = 1'b0;
                    w_cmd_out = 1'b1;
                end else begin
                    w_cmd_out = r_tx[47];
                    w_tx      = {r_tx[46:0], 1'b1};
                    w_cnt     = r_cnt + 7'd1;
                end
            end
            default: w_state = S_RX_WAIT;
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RX_WAIT;
            r_rx      <= '0;
            r_tx      <= '1;
            r_cnt     <= 7'd0;
            r_busy    <= 8'd0;
            r_app     <= 1'b0;
            r_cmd_out <= 1'b1;
            r_cmd_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_crc_err <= 1'b0;
            r_illegal <= 1'b0;
            r_index   <= 6'd0;
            r_card    <= c_IDLE;
        end else begin
            r_state   <= w_state;
            r_rx      <= w_rx;
            r_tx      <= w_tx;
            r_cnt     <= w_cnt;
            r_busy    <= w_busy;
            r_app     <= w_app;
            r_cmd_out <= w_cmd_out;
            r_cmd_oe  <= w_cmd_oe;
            r_done    <= w_done;
            r_crc_err <= w_crc_err;
            r_illegal <= w_illegal;
            r_index   <= w_index;
            r_card    <= w_card;
        end
    end

    assign cmd_out     = r_cmd_out;
    assign cmd_oe      = r_cmd_oe;
    assign cmd_done    = r_done;
    assign cmd_index   = r_index;
    assign crc_error   = r_crc_err;
    assign illegal_cmd = r_illegal;
    assign card_state  = r_card;

endmodule
`default_nettype wire
